// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the lane masks used when merging sub-word stores.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] LANE_B_MASK = 32'h0000_00FF;
    localparam logic [31:0] LANE_H_MASK = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_STORE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    // Unsigned widths exist only for loads; halfwords need even, words
    // need 4-byte-aligned addresses.
    function automatic logic req_is_err(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge
// for a single 32-bit memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_word
);

    logic [4:0]  w_bshift;
    logic [4:0]  w_hshift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mask;
    logic [31:0] w_ins;

    always_comb begin
        w_bshift = {i_off, 3'b000};
        w_hshift = {i_off[1], 4'b0000};
        w_byte   = 8'(i_word >> w_bshift);
        w_half   = 16'(i_word >> w_hshift);

        o_load_data = i_word;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h000000, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0000, w_half};
            default: o_load_data = i_word;
        endcase

        // Only SB/SH reach the merge path, so funct3[1:0] picks the lane size.
        if (i_funct3[1:0] == 2'b00) begin
            w_mask = LANE_B_MASK << w_bshift;
            w_ins  = {24'h000000, i_wdata[7:0]} << w_bshift;
        end else begin
            w_mask = LANE_H_MASK << w_hshift;
            w_ins  = {16'h0000, i_wdata} << w_hshift;
        end
        o_merge_word = (i_word & ~w_mask) | w_ins;
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one RV32I load/store, drives a word-only memory
// and returns a single-cycle response; sub-word stores use read-modify-write.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_r_addr,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  o_dbg_state
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_off;
    logic [2:0]        r_funct3;
    logic [15:0]       r_wdata;
    logic [31:0]       r_merge;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              w_req_err;
    logic [31:0]       w_index;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merge_word;
    logic              w_unused_bits;

    // Byte-address bits above the word index and the upper store half are
    // intentionally dropped (index wraps within the memory).
    assign w_unused_bits = &{1'b0, req_addr[31:ADDR_W+2], req_wdata[31:16]};

    assign w_req_err = req_is_err(req_we, req_funct3, req_addr[1:0]);
    assign w_index   = {{(32-ADDR_W){1'b0}}, r_idx};

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_off        (r_off),
        .i_word       (mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_word (w_merge_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_off    <= 2'b00;
            r_funct3 <= 3'b000;
            r_wdata  <= 16'h0000;
            r_merge  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_idx    <= req_addr[ADDR_W+1:2];
                        r_off    <= req_addr[1:0];
                        r_funct3 <= req_funct3;
                        r_wdata  <= req_wdata[15:0];
                        r_merge  <= req_wdata;
                        if (w_req_err) begin
                            r_rdata <= 32'h0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    r_rdata <= w_load_data;
                    r_err   <= 1'b0;
                end
                ST_RMW_RD: r_merge <= w_merge_word;
                ST_STORE: begin
                    r_rdata <= 32'h0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_err)           w_next = ST_RESP;
                    else if (!req_we)        w_next = ST_LOAD;
                    else if (req_funct3 == F3_W) w_next = ST_STORE;
                    else                     w_next = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                mem_read = 1'b1;
                w_next   = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_read = 1'b1;
                w_next   = ST_STORE;
            end
            ST_STORE: begin
                // Reset sampled on this edge must not let the write commit.
                mem_write = rst_n;
                w_next    = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign mem_r_addr  = w_index;
    assign mem_w_addr  = w_index;
    assign mem_wdata   = r_merge;
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a 32-word memory model, one task per scenario,
// hand-computed expected values.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    logic [31:0] mem [32];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          overlap_cnt = 0;
    logic [31:0] last_rd_idx = '0;
    logic [31:0] last_wr_idx = '0;

    int          errors = 0;
    int          checks = 0;

    int          got_lat;
    logic [31:0] got_rdata;
    logic        got_err;
    logic        got_ready;
    int          got_rd;
    int          got_wr;

    lsu #(.ADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_r_addr  (mem_r_addr),
        .mem_w_addr  (mem_w_addr),
        .mem_wdata   (mem_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_r_addr[4:0]];

    always @(posedge clk) begin
        if (mem_read) begin
            rd_cnt++;
            last_rd_idx = mem_r_addr;
        end
        if (mem_write) begin
            wr_cnt++;
            last_wr_idx = mem_w_addr;
            mem[mem_w_addr[4:0]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) overlap_cnt++;
    end

    // Issue one request from IDLE and wait (bounded) for its response strobe.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        int rd0, wr0;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got_lat = -1;
        for (int i = 1; i <= 8 && got_lat < 0; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got_lat   = i;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                got_ready = req_ready;
            end
        end
        got_rd = rd_cnt - rd0;
        got_wr = wr_cnt - wr0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", resp_err); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_mem_en: got %b want 00", {mem_read, mem_write}); end
        checks++; if ({mem_r_addr, mem_w_addr, mem_wdata} !== 96'h0) begin errors++; $display("FAIL reset_mem_bus: got %h %h %h want 0", mem_r_addr, mem_w_addr, mem_wdata); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst_n = 1'b1;
    endtask

    task automatic test_load;
        do_req(1'b0, F3_B, 32'h7, 32'h0);
        checks++; if (got_rdata !== 32'hFFFF_FF80 || got_err !== 1'b0) begin errors++; $display("FAIL lb_0x7: got %h err %b want ffffff80 err 0", got_rdata, got_err); end
        checks++; if (got_lat !== 2 || got_rd !== 1 || got_wr !== 0) begin errors++; $display("FAIL lb_timing: lat %0d rd %0d wr %0d want 2 1 0", got_lat, got_rd, got_wr); end
        do_req(1'b0, F3_BU, 32'h7, 32'h0);
        checks++; if (got_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_0x7: got %h want 00000080", got_rdata); end
        do_req(1'b0, F3_H, 32'h6, 32'h0);
        checks++; if (got_rdata !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_0x6: got %h want ffff80ff", got_rdata); end
        do_req(1'b0, F3_HU, 32'h4, 32'h0);
        checks++; if (got_rdata !== 32'h0000_1234) begin errors++; $display("FAIL lhu_0x4: got %h want 00001234", got_rdata); end
        do_req(1'b0, F3_B, 32'h4, 32'h0);
        checks++; if (got_rdata !== 32'h0000_0034) begin errors++; $display("FAIL lb_0x4: got %h want 00000034", got_rdata); end
    endtask

    task automatic test_store_sub;
        do_req(1'b1, F3_B, 32'h9, 32'hFFFF_FFAB);
        checks++; if (mem[2] !== 32'h1122_AB44) begin errors++; $display("FAIL sb_0x9_mem: got %h want 1122ab44", mem[2]); end
        checks++; if (got_lat !== 3 || got_rd !== 1 || got_wr !== 1) begin errors++; $display("FAIL sb_timing: lat %0d rd %0d wr %0d want 3 1 1", got_lat, got_rd, got_wr); end
        checks++; if (last_wr_idx !== 32'd2) begin errors++; $display("FAIL sb_windex: got %0d want 2", last_wr_idx); end
        checks++; if (got_rdata !== 32'h0 || got_err !== 1'b0) begin errors++; $display("FAIL sb_resp: got %h err %b want 0 err 0", got_rdata, got_err); end
        mem[1] = 32'h0;
        do_req(1'b1, F3_H, 32'h6, 32'h1234_BEEF);
        checks++; if (mem[1] !== 32'hBEEF_0000) begin errors++; $display("FAIL sh_0x6_mem: got %h want beef0000", mem[1]); end
        do_req(1'b1, F3_H, 32'h8, 32'h0000_5A5A);
        checks++; if (mem[2] !== 32'h1122_5A5A) begin errors++; $display("FAIL sh_0x8_mem: got %h want 11225a5a", mem[2]); end
    endtask

    task automatic test_errors;
        do_req(1'b0, F3_H, 32'h3, 32'h0);
        checks++; if (got_err !== 1'b1 || got_rdata !== 32'h0) begin errors++; $display("FAIL lh_0x3_err: got %h err %b want 0 err 1", got_rdata, got_err); end
        checks++; if (got_lat !== 1 || got_rd !== 0 || got_wr !== 0) begin errors++; $display("FAIL lh_0x3_timing: lat %0d rd %0d wr %0d want 1 0 0", got_lat, got_rd, got_wr); end
        do_req(1'b0, F3_HU, 32'h4, 32'h0);
        do_req(1'b0, 3'b011, 32'h0, 32'h0);
        checks++; if (got_err !== 1'b1 || got_rdata !== 32'h0) begin errors++; $display("FAIL ld_f3_011: got %h err %b want 0 err 1", got_rdata, got_err); end
        do_req(1'b1, F3_W, 32'h2, 32'hFFFF_FFFF);
        checks++; if (got_err !== 1'b1 || got_wr !== 0 || mem[0] !== 32'h0) begin errors++; $display("FAIL sw_misaligned: err %b wr %0d mem0 %h want 1 0 0", got_err, got_wr, mem[0]); end
        do_req(1'b1, F3_BU, 32'h0, 32'hFFFF_FFFF);
        checks++; if (got_err !== 1'b1 || got_wr !== 0) begin errors++; $display("FAIL st_f3_100: err %b wr %0d want 1 0", got_err, got_wr); end
    endtask

    task automatic test_back_to_back;
        do_req(1'b1, F3_W, 32'h0, 32'hDEAD_BEEF);
        checks++; if (got_lat !== 2 || got_rd !== 0 || got_wr !== 1 || got_ready !== 1'b0) begin errors++; $display("FAIL sw_b2b: lat %0d rd %0d wr %0d ready %b want 2 0 1 0", got_lat, got_rd, got_wr, got_ready); end
        do_req(1'b0, F3_W, 32'h0, 32'h0);
        checks++; if (got_rdata !== 32'hDEAD_BEEF || got_lat !== 2) begin errors++; $display("FAIL lw_b2b: got %h lat %0d want deadbeef 2", got_rdata, got_lat); end
        checks++; if (got_ready !== 1'b0) begin errors++; $display("FAIL ready_in_resp: got %b want 0", got_ready); end
    endtask

    task automatic test_wrap;
        do_req(1'b0, F3_W, 32'h84, 32'h0);
        checks++; if (last_rd_idx !== 32'd1 || got_rdata !== 32'hBEEF_0000) begin errors++; $display("FAIL lw_wrap_0x84: idx %0d data %h want 1 beef0000", last_rd_idx, got_rdata); end
        do_req(1'b1, F3_W, 32'h80, 32'h0BAD_F00D);
        checks++; if (last_wr_idx !== 32'd0 || mem[0] !== 32'h0BAD_F00D) begin errors++; $display("FAIL sw_wrap_0x80: idx %0d mem0 %h want 0 0badf00d", last_wr_idx, mem[0]); end
    endtask

    task automatic test_reset_mid_store;
        int wr0;
        mem[3] = 32'h55AA_55AA;
        @(negedge clk);
        wr0 = wr_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'hC;
        req_wdata  = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++; if (dbg_state !== ST_STORE) begin errors++; $display("FAIL mid_store_state: got %0d want 3", dbg_state); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL mid_store_gate: got %b want 0", mem_write); end
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (dbg_state !== ST_IDLE || resp_valid !== 1'b0) begin errors++; $display("FAIL mid_store_abort: state %0d valid %b want 0 0", dbg_state, resp_valid); end
        checks++; if (mem[3] !== 32'h55AA_55AA || wr_cnt != wr0) begin errors++; $display("FAIL mid_store_nowrite: mem3 %h writes %0d want 55aa55aa 0", mem[3], wr_cnt - wr0); end
        do_req(1'b0, F3_W, 32'hC, 32'h0);
        checks++; if (got_rdata !== 32'h55AA_55AA || got_lat !== 2) begin errors++; $display("FAIL lw_after_abort: got %h lat %0d want 55aa55aa 2", got_rdata, got_lat); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[1] = 32'h80FF_1234;
        mem[2] = 32'h1122_3344;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        test_reset();
        test_load();
        test_store_sub();
        test_errors();
        test_back_to_back();
        test_wrap();
        test_reset_mid_store();

        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL rw_overlap: got %0d cycles want 0", overlap_cnt); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the word-only data memory. Accepts one RV32I load or store per request, converts byte addresses to word indices, performs byte/halfword lane extraction and sign/zero extension for loads, and sequences read-modify-write for sub-word stores. The memory never sees a simultaneous read and write. Results and misalignment errors return on a single-cycle response strobe.

## Interface
- `ADDR_W`, default 5: width of the word index driven to memory; byte-address bits [ADDR_W+1:2] are used, upper bits ignored.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle, can accept this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code; loads LB=000, LH=001, LW=010, LBU=100, LHU=101; stores SB=000, SH=001, SW=010.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion strobe.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal funct3; valid with `resp_valid`.
- `mem_r_addr` out 32: word index, zero-extended from ADDR_W bits.
- `mem_w_addr` out 32: word index, zero-extended from ADDR_W bits.
- `mem_wdata` out 32: full word to write.
- `mem_read` out 1: read enable; memory data is combinational in the same cycle.
- `mem_write` out 1: write enable; memory commits on the rising edge.
- `mem_rdata` in 32: memory read data.

## Operation
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch addr, we, funct3, wdata, and branch:
  - Error: illegal funct3 (load 011/110/111; store ≥011), halfword with addr[0]=1, or word with addr[1:0]≠0 → RESP with err=1. No memory access.
  - Load → LOAD.
  - SW → STORE, with the merge register = wdata.
  - SB/SH → RMW_RD.
- LOAD: `mem_read`=1, `mem_r_addr`=index. Extract lane, extend into the `resp_rdata` register → RESP.
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (bits [15:0] or [31:16]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
- RMW_RD: `mem_read`=1. Merge register = mem_rdata with the target lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH) → STORE.
- STORE: `mem_write`=1, `mem_w_addr`=index, `mem_wdata`=merge register → RESP.
- RESP: `resp_valid`=1, `req_ready`=0 → IDLE.
- `mem_read` and `mem_write` decode from state only and are never both 1.
- `mem_write` is gated with `rst_n`, so no write commits on an edge where reset is sampled.
- Address wrap: index bits above ADDR_W are dropped; address 0x80 with ADDR_W=5 hits index 0.

## Timing
- Reset values: state IDLE; `req_ready` 1; `resp_valid` 0; `resp_rdata` 0; `resp_err` 0; `mem_read` 0; `mem_write` 0; `mem_r_addr`, `mem_w_addr`, `mem_wdata` 0.
- Acceptance edge = E0 (IDLE and `req_valid`). `resp_valid` is high in the cycle after:
  - Error: E1.
  - Load or SW: E2.
  - SB/SH: E3.
- Throughput: one request per latency+1 cycles. `req_valid` while not ready is ignored; the requester holds it.
- `resp_rdata`/`resp_err` hold until the next response or reset.
- Reset mid-operation aborts to IDLE at the sampling edge. No partial write; `resp_valid` is not issued.

## Structure
- `lsu_pkg`: funct3 constants, state enum, lane-select helper constants.
- One sub-module `lsu_align`, purely combinational. It provides load extract/extend and store lane merge, so both are unit-testable.
- FSM and registers live in `lsu`.

## Test plan
- LB from addr 0x7 with word[1]=0x80FF_1234 → `resp_rdata`=0xFFFF_FF80, err=0, `resp_valid` 2 cycles after acceptance. LBU from the same address → 0x0000_0080.
- SB 0xAB to 0x9 over word[2]=0x1122_3344 → one `mem_read` cycle, then one `mem_write` with 0x1122_AB44 to index 2; response after 3 cycles.
- SH to 0x6 (0xBEEF) over word[1]=0 → 0xBEEF_0000. LH from 0x3 → err=1, no `mem_read`/`mem_write` asserted, response after 1 cycle.
- Back-to-back SW 0xDEAD_BEEF to 0x0, then LW from 0x0 → 0xDEAD_BEEF. Check that `req_ready` drops between requests and that `mem_read`&`mem_write` is never 1.
- `rst_n` low during STORE → no write to memory, state IDLE, `resp_valid` 0; a subsequent LW returns the old value.
- Illegal load funct3 011 → err=1, `resp_rdata`=0. LW from 0x84 with ADDR_W=5 → accesses index 1.
